// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution stream transmitter.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILT,
    ST_GAP,
    ST_IMG,
    ST_WAIT_OUT
  } tx_state_e;

  localparam int FILT3_BEATS = 9;
  localparam int FILT5_BEATS = 25;
  localparam int MAX_IMG     = 8;
  localparam int PAD         = 2;

  // A 5x5 filter needs at least a 5x5 image; nothing below 3x3 is supported.
  function automatic logic cfg_legal(input logic fsz, input logic [3:0] n,
                                     input logic [3:0] max_n);
    return (n >= 4'd3) && (n <= max_n) && (!fsz || (n >= 4'd5));
  endfunction

endpackage

// File: rtl/conv_tx_buf.sv
// Filter and image register files: one write port, one combinational read port.
// Contents are not reset; out-of-range filter addresses are dropped on write and read as 0.
module conv_tx_buf #(
  parameter int FILT_DEPTH = 25,
  parameter int IMG_DEPTH  = 64
) (
  input  logic       clk,
  input  logic       i_wr_en,
  input  logic       i_wr_sel,
  input  logic [5:0] i_wr_addr,
  input  logic [7:0] i_wr_dat,
  input  logic       i_rd_sel,
  input  logic [5:0] i_rd_addr,
  output logic [7:0] o_rd_dat
);

  localparam int FW = $clog2(FILT_DEPTH);

  logic [7:0] r_filt [FILT_DEPTH];
  logic [7:0] r_img  [IMG_DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      if (i_wr_sel) begin
        if (int'(i_wr_addr) < IMG_DEPTH) r_img[i_wr_addr] <= i_wr_dat;
      end else if (int'(i_wr_addr) < FILT_DEPTH) begin
        r_filt[i_wr_addr[FW-1:0]] <= i_wr_dat;
      end
    end
  end

  always_comb begin
    o_rd_dat = 8'd0;
    if (i_rd_sel) begin
      if (int'(i_rd_addr) < IMG_DEPTH) o_rd_dat = r_img[i_rd_addr];
    end else if (int'(i_rd_addr) < FILT_DEPTH) begin
      o_rd_dat = r_filt[i_rd_addr[FW-1:0]];
    end
  end

endmodule

// File: rtl/conv_stream_tx.sv
// Streams one filter burst, a one-cycle gap and one image burst to the conv core,
// then counts out_valid results until the frame completes or times out.
module conv_stream_tx #(
  parameter int MAX_IMG    = 8,
  parameter int FILT_DEPTH = 25,
  parameter int TIMEOUT    = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld_valid,
  input  logic       ld_sel,
  input  logic [5:0] ld_addr,
  input  logic [7:0] ld_data,
  input  logic       cfg_filter_size,
  input  logic [3:0] cfg_image_size,
  input  logic       cfg_pad_mode,
  input  logic       cfg_act_mode,
  input  logic       start,
  input  logic       out_valid,
  output logic       filter_valid,
  output logic       image_valid,
  output logic       filter_size,
  output logic [3:0] image_size,
  output logic       pad_mode,
  output logic       act_mode,
  output logic [7:0] in_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [6:0] res_cnt
);

  import conv_pkg::*;

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  tx_state_e       r_state;
  logic [6:0]      r_cnt;
  logic [TO_W-1:0] r_to;
  logic            r_fsz, r_pad, r_act;
  logic [3:0]      r_n;

  logic            r_filter_valid, r_image_valid, r_filter_size, r_pad_mode, r_act_mode;
  logic [3:0]      r_image_size;
  logic [7:0]      r_in_data;
  logic            r_busy, r_done, r_err;
  logic [6:0]      r_res_cnt;

  logic            w_wr_en, w_rd_sel, w_cfg_ok;
  logic [5:0]      w_rd_addr;
  logic [7:0]      w_rd_dat, w_beat;
  logic [6:0]      w_kk, w_nn, w_res_nxt;

  assign w_wr_en   = ld_valid && (r_state == ST_IDLE);
  assign w_rd_sel  = (r_state == ST_GAP) || (r_state == ST_IMG);
  assign w_rd_addr = (r_state == ST_IDLE) ? 6'd0 : r_cnt[5:0];
  assign w_kk      = r_fsz ? 7'(FILT5_BEATS) : 7'(FILT3_BEATS);
  assign w_nn      = {3'd0, r_n} * {3'd0, r_n};
  assign w_cfg_ok  = cfg_legal(cfg_filter_size, cfg_image_size, 4'(MAX_IMG));

  // A word written on the start cycle must already appear in this frame's first beat.
  assign w_beat = (w_wr_en && (ld_sel == w_rd_sel) && (ld_addr == w_rd_addr)) ? ld_data : w_rd_dat;

  always_comb begin
    w_res_nxt = r_res_cnt;
    if (((r_state == ST_IMG) || (r_state == ST_WAIT_OUT)) && out_valid && (r_res_cnt != 7'h7F))
      w_res_nxt = r_res_cnt + 7'd1;
  end

  conv_tx_buf #(
    .FILT_DEPTH (FILT_DEPTH),
    .IMG_DEPTH  (MAX_IMG * MAX_IMG)
  ) u_buf (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_sel  (ld_sel),
    .i_wr_addr (ld_addr),
    .i_wr_dat  (ld_data),
    .i_rd_sel  (w_rd_sel),
    .i_rd_addr (w_rd_addr),
    .o_rd_dat  (w_rd_dat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_to           <= '0;
      r_fsz          <= 1'b0;
      r_n            <= '0;
      r_pad          <= 1'b0;
      r_act          <= 1'b0;
      r_filter_valid <= 1'b0;
      r_image_valid  <= 1'b0;
      r_filter_size  <= 1'b0;
      r_image_size   <= '0;
      r_pad_mode     <= 1'b0;
      r_act_mode     <= 1'b0;
      r_in_data      <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_res_cnt      <= '0;
    end else begin
      r_filter_valid <= 1'b0;
      r_image_valid  <= 1'b0;
      r_filter_size  <= 1'b0;
      r_image_size   <= '0;
      r_pad_mode     <= 1'b0;
      r_act_mode     <= 1'b0;
      r_in_data      <= '0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_res_cnt      <= w_res_nxt;
      // r_state names what the output registers carry during the current cycle.
      case (r_state)
        ST_IDLE: begin
          r_to <= '0;
          if (start && !r_done) begin
            if (w_cfg_ok) begin
              r_fsz          <= cfg_filter_size;
              r_n            <= cfg_image_size;
              r_pad          <= cfg_pad_mode;
              r_act          <= cfg_act_mode;
              r_res_cnt      <= '0;
              r_cnt          <= 7'd1;
              r_state        <= ST_FILT;
              r_busy         <= 1'b1;
              r_filter_valid <= 1'b1;
              r_in_data      <= w_beat;
              r_filter_size  <= cfg_filter_size;
              r_image_size   <= cfg_image_size;
              r_pad_mode     <= cfg_pad_mode;
              r_act_mode     <= cfg_act_mode;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_FILT: begin
          if (r_cnt < w_kk) begin
            r_filter_valid <= 1'b1;
            r_in_data      <= w_beat;
            r_cnt          <= r_cnt + 7'd1;
          end else begin
            r_cnt   <= '0;
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          r_image_valid <= 1'b1;
          r_in_data     <= w_beat;
          r_cnt         <= 7'd1;
          r_state       <= ST_IMG;
        end
        ST_IMG: begin
          if (r_cnt < w_nn) begin
            r_image_valid <= 1'b1;
            r_in_data     <= w_beat;
            r_cnt         <= r_cnt + 7'd1;
          end else begin
            r_to    <= '0;
            r_state <= ST_WAIT_OUT;
          end
        end
        ST_WAIT_OUT: begin
          if (w_res_nxt >= w_nn) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (out_valid) begin
            r_to <= '0;
          end else if (r_to == TO_LAST) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_to <= r_to + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign filter_valid = r_filter_valid;
  assign image_valid  = r_image_valid;
  assign filter_size  = r_filter_size;
  assign image_size   = r_image_size;
  assign pad_mode     = r_pad_mode;
  assign act_mode     = r_act_mode;
  assign in_data      = r_in_data;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;
  assign res_cnt      = r_res_cnt;

endmodule

// File: tb/tb_conv_stream_tx.sv
// Directed bench for conv_stream_tx with a fixed-latency core model returning one result per image beat.
module tb_conv_stream_tx;

  localparam int TIMEOUT = 1023;
  localparam int LAT     = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld_valid = 1'b0, ld_sel = 1'b0;
  logic [5:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic       cfg_filter_size = 1'b0, cfg_pad_mode = 1'b0, cfg_act_mode = 1'b0;
  logic [3:0] cfg_image_size = '0;
  logic       start = 1'b0;
  logic       out_valid = 1'b0;
  logic       filter_valid, image_valid, filter_size, pad_mode, act_mode;
  logic [3:0] image_size;
  logic [7:0] in_data;
  logic       busy, done, err;
  logic [6:0] res_cnt;

  always #5 clk = ~clk;

  conv_stream_tx #(.MAX_IMG(8), .FILT_DEPTH(25), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .cfg_filter_size(cfg_filter_size), .cfg_image_size(cfg_image_size),
    .cfg_pad_mode(cfg_pad_mode), .cfg_act_mode(cfg_act_mode),
    .start(start), .out_valid(out_valid),
    .filter_valid(filter_valid), .image_valid(image_valid),
    .filter_size(filter_size), .image_size(image_size),
    .pad_mode(pad_mode), .act_mode(act_mode), .in_data(in_data),
    .busy(busy), .done(done), .err(err), .res_cnt(res_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference copies of the buffers, updated only by legal loads.
  logic [7:0] fbuf [25];
  logic [7:0] ibuf [64];
  logic [7:0] fe[$], ie[$];

  logic [7:0] fq[$], iq[$];
  int cyc = 0, start_cyc = 0;
  int n_done = 0, n_errp = 0, cfg_stray = 0, data_stray = 0, busy_hi = 0;
  int first_f_cyc = -1, last_f_cyc = -1, first_i_cyc = -1, last_ov_cyc = -1, err_cyc = -1;
  logic       f0_fsz = 1'b0, f0_pad = 1'b0, f0_act = 1'b0;
  logic [3:0] f0_isz = '0;
  int ov_limit = 0, ov_given = 0;
  logic [LAT-1:0] sr = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (filter_valid) begin
      if (fq.size() == 0) begin
        f0_fsz = filter_size; f0_isz = image_size; f0_pad = pad_mode; f0_act = act_mode;
        first_f_cyc = cyc;
      end else if (filter_size || image_size != 4'd0 || pad_mode || act_mode) cfg_stray++;
      last_f_cyc = cyc;
      fq.push_back(in_data);
    end else if (filter_size || image_size != 4'd0 || pad_mode || act_mode) cfg_stray++;
    if (image_valid) begin
      if (iq.size() == 0) first_i_cyc = cyc;
      iq.push_back(in_data);
    end
    if (!filter_valid && !image_valid && in_data != 8'd0) data_stray++;
    if (busy) busy_hi++;
    if (done) n_done++;
    if (err) begin n_errp++; err_cyc = cyc; end
    // core model: one result per image beat, LAT cycles later, capped at ov_limit
    sr = {sr[LAT-2:0], image_valid};
    out_valid = sr[LAT-1] && (ov_given < ov_limit);
    if (out_valid) begin ov_given++; last_ov_cyc = cyc; end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    fq.delete(); iq.delete();
    n_done = 0; n_errp = 0; cfg_stray = 0; data_stray = 0; busy_hi = 0;
    first_f_cyc = -1; last_f_cyc = -1; first_i_cyc = -1; err_cyc = -1; last_ov_cyc = -1;
    ov_given = 0; sr = '0;
  endtask

  task automatic wr(input logic sel, input int a, input int d);
    ld_valid = 1'b1; ld_sel = sel; ld_addr = 6'(a); ld_data = 8'(d);
    if (sel) ibuf[a] = 8'(d); else fbuf[a] = 8'(d);
    step();
    ld_valid = 1'b0;
  endtask

  task automatic kick(input logic fsz, input int n, input logic pad, input logic act);
    cfg_filter_size = fsz; cfg_image_size = 4'(n); cfg_pad_mode = pad; cfg_act_mode = act;
    start = 1'b1;
    start_cyc = cyc + 1;
    step();
    start = 1'b0;
  endtask

  task automatic expect_frame(input logic fsz, input int n);
    fe.delete(); ie.delete();
    for (int i = 0; i < (fsz ? 25 : 9); i++) fe.push_back(fbuf[i]);
    for (int i = 0; i < n * n; i++) ie.push_back(ibuf[i]);
  endtask

  task automatic wait_end(input int budget, input string tag);
    int i;
    for (i = 0; i < budget; i++) begin
      if (n_done != 0 || n_errp != 0) break;
      step();
    end
    chk($sformatf("%s ended", tag), 32'((n_done + n_errp) != 0), 1);
  endtask

  task automatic chk_stream(input string tag);
    chk($sformatf("%s filt_beats", tag), fq.size(), fe.size());
    for (int i = 0; i < fe.size(); i++)
      chk($sformatf("%s f%0d", tag, i), (i < fq.size()) ? 32'(fq[i]) : 32'hFFFF_FFFF, fe[i]);
    chk($sformatf("%s img_beats", tag), iq.size(), ie.size());
    for (int i = 0; i < ie.size(); i++)
      chk($sformatf("%s i%0d", tag, i), (i < iq.size()) ? 32'(iq[i]) : 32'hFFFF_FFFF, ie[i]);
    chk($sformatf("%s first_beat_cyc", tag), first_f_cyc, start_cyc);
    chk($sformatf("%s gap", tag), first_i_cyc - last_f_cyc, 2);
    chk($sformatf("%s cfg_stray", tag), cfg_stray, 0);
    chk($sformatf("%s data_stray", tag), data_stray, 0);
  endtask

  initial begin
    int c;
    repeat (3) step();
    chk("rst filter_valid", filter_valid, 0);
    chk("rst image_valid", image_valid, 0);
    chk("rst in_data", in_data, 0);
    chk("rst busy", busy, 0);
    chk("rst done_err", {done, err}, 0);
    chk("rst res_cnt", res_cnt, 0);
    chk("rst cfg_out", {filter_size, image_size, pad_mode, act_mode}, 0);
    rst = 1'b0;
    step();

    // 3x3 all-ones filter, 4x4 image 1..16
    for (int i = 0; i < 9; i++) wr(1'b0, i, 1);
    for (int i = 0; i < 16; i++) wr(1'b1, i, i + 1);
    clear_mon(); ov_limit = 1000; expect_frame(1'b0, 4);
    kick(1'b0, 4, 1'b0, 1'b0);
    wait_end(300, "t1");
    step();
    chk_stream("t1");
    chk("t1 isz0", f0_isz, 4);
    chk("t1 fsz_pad_act0", {f0_fsz, f0_pad, f0_act}, 0);
    chk("t1 done", n_done, 1);
    chk("t1 err", n_errp, 0);
    chk("t1 res_cnt", res_cnt, 16);
    chk("t1 busy", busy, 0);

    // 5x5 filter 0..24, 8x8 image, pad 1, act 1
    for (int i = 0; i < 25; i++) wr(1'b0, i, i);
    for (int i = 0; i < 64; i++) wr(1'b1, i, (i * 7 + 3) & 255);
    clear_mon(); expect_frame(1'b1, 8);
    kick(1'b1, 8, 1'b1, 1'b1);
    wait_end(400, "t2");
    step();
    chk_stream("t2");
    chk("t2 cfg0", {f0_fsz, f0_isz, f0_pad, f0_act}, {1'b1, 4'd8, 1'b1, 1'b1});
    chk("t2 done", n_done, 1);
    chk("t2 res_cnt", res_cnt, 64);

    // illegal configs
    foreach (ie[k]) ie[k] = ie[k];
    for (int t = 0; t < 2; t++) begin
      clear_mon();
      kick(1'b1, (t == 0) ? 4 : 9, 1'b0, 1'b0);
      repeat (5) step();
      chk($sformatf("t3.%0d err", t), n_errp, 1);
      chk($sformatf("t3.%0d busy", t), busy_hi, 0);
      chk($sformatf("t3.%0d beats", t), fq.size() + iq.size(), 0);
      chk($sformatf("t3.%0d res_cnt", t), res_cnt, 64);
    end

    // timeout: core returns only 10 of 16 results
    clear_mon(); ov_limit = 10;
    kick(1'b0, 4, 1'b0, 1'b0);
    wait_end(TIMEOUT + 300, "t4");
    step();
    chk("t4 err", n_errp, 1);
    chk("t4 done", n_done, 0);
    // last out_valid is sampled on the edge that makes cyc = last_ov_cyc+1
    chk("t4 err_delay", err_cyc - (last_ov_cyc + 1), TIMEOUT);
    chk("t4 res_cnt", res_cnt, 10);
    chk("t4 busy", busy, 0);
    chk("t4 img_beats", iq.size(), 16);

    // reset on the 5th image beat, then replay
    clear_mon(); ov_limit = 1000;
    kick(1'b0, 4, 1'b0, 1'b0);
    for (c = 0; c < 100 && iq.size() < 5; c++) step();
    chk("t5 reached beat5", iq.size(), 5);
    rst = 1'b1;
    step();
    chk("t5 valids", {filter_valid, image_valid}, 0);
    chk("t5 in_data", in_data, 0);
    chk("t5 cfg_out", {filter_size, image_size, pad_mode, act_mode}, 0);
    chk("t5 busy_res", {busy, res_cnt}, 0);
    rst = 1'b0;
    repeat (LAT + 5) step();
    chk("t5 no done_err", n_done + n_errp, 0);
    clear_mon(); expect_frame(1'b0, 4);
    kick(1'b0, 4, 1'b0, 1'b0);
    wait_end(300, "t5b");
    step();
    chk_stream("t5b");
    chk("t5b done", n_done, 1);

    // start and loads during IMG must not disturb the frame or the buffers
    clear_mon();
    kick(1'b0, 4, 1'b0, 1'b0);
    for (c = 0; c < 100 && iq.size() < 3; c++) step();
    ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 6'd5; ld_data = 8'hEE; start = 1'b1;
    step();
    ld_sel = 1'b0; ld_addr = 6'd0; ld_data = 8'hDD;
    step();
    ld_valid = 1'b0; start = 1'b0;
    wait_end(300, "t6");
    step();
    chk_stream("t6");
    chk("t6 done", n_done, 1);
    clear_mon();
    kick(1'b0, 4, 1'b0, 1'b0);
    wait_end(300, "t6b");
    step();
    chk_stream("t6b");

    // write coincident with start; then start on the done cycle is ignored
    ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 6'd0; ld_data = 8'h7F;
    fbuf[0] = 8'h7F;
    clear_mon(); expect_frame(1'b0, 3);
    kick(1'b0, 3, 1'b0, 1'b1);
    ld_valid = 1'b0;
    wait_end(300, "t7");
    chk("t7 done_now", done, 1);
    c = fq.size();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t7 start_on_done busy", busy, 0);
    chk("t7 start_on_done beats", fq.size(), c);
    chk_stream("t7");
    chk("t7 act0", f0_act, 1);
    chk("t7 res_cnt", res_cnt, 9);
    kick(1'b0, 3, 1'b0, 1'b0);
    chk("t7 restart busy", busy, 1);
    chk("t7 restart beat0", filter_valid, 1);
    wait_end(300, "t7b");
    step();

    $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
    $finish;
  end

endmodule
